// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box and round-constant tables, FSM states,
// the 128-bit block type and the per-clock iteration count.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry 0 is unused: round constants are indexed by absolute round 1..10.
  localparam logic [7:0] RCON [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic int iters(input int rounds_per_cycle);
    return 10 / rounds_per_cycle;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    return (rnd <= 4'd10) ? RCON[rnd] : 8'h00;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_step.sv
// One AES-128 encryption round with on-the-fly expansion of the next round key.
module aes_round_step
  import aes_pkg::*;
(
  input  aes_block_t  state,
  input  aes_block_t  round_key,
  input  logic [7:0]  rcon,
  input  logic        is_final,
  output aes_block_t  next_state,
  output aes_block_t  next_key
);

  logic [31:0] temp;
  logic [7:0]  sb  [16];
  logic [7:0]  sr  [16];
  logic [7:0]  mix [16];

  always_comb begin
    temp = {sbox(round_key[23:16]), sbox(round_key[15:8]),
            sbox(round_key[7:0]),   sbox(round_key[31:24])} ^ {rcon, 24'h0};
    next_key[127:96] = round_key[127:96] ^ temp;
    next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
    next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
    next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];
  end

  // Bytes are column-major: byte i sits at row i%4, column i/4.
  always_comb begin
    next_state = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(state[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mix[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mix[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mix[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mix[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int i = 0; i < 16; i++)
      next_state[127-8*i -: 8] = (is_final ? sr[i] : mix[i]) ^ next_key[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock.
// Define AES_ITER_CBC_EN to chain blocks in CBC mode; otherwise plain ECB.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         chain_start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cryptokey,
  output logic         busy
);

  localparam int ITERS = iters(ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rounds
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2 or 5");
  end

  aes_state_e  state_q;
  aes_block_t  blk_q;
  aes_block_t  rkey_q;
  aes_block_t  cryptokey_q;
  logic [3:0]  cnt_q;
  aes_block_t  chain_val;

  aes_block_t  stage_state [ROUNDS_PER_CYCLE+1];
  aes_block_t  stage_key   [ROUNDS_PER_CYCLE+1];

  assign stage_state[0] = blk_q;
  assign stage_key[0]   = rkey_q;

  // Stage i evaluates absolute round cnt*R + i + 1, so the rcon lookup tracks it.
  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    logic [3:0] rnd;
    assign rnd = cnt_q * 4'(ROUNDS_PER_CYCLE) + 4'(i + 1);

    aes_round_step u_step (
      .state      (stage_state[i]),
      .round_key  (stage_key[i]),
      .rcon       (rcon_of(rnd)),
      .is_final   (rnd == 4'd10),
      .next_state (stage_state[i+1]),
      .next_key   (stage_key[i+1])
    );
  end

`ifdef AES_ITER_CBC_EN
  aes_block_t chain_q;

  always_ff @(posedge clk) begin
    if (reset)
      chain_q <= '0;
    else if (state_q == DONE && out_ready)
      chain_q <= cryptokey_q;
  end

  assign chain_val = chain_start ? iv : chain_q;
`else
  logic unused_cbc;
  assign unused_cbc = ^{iv, chain_start};
  assign chain_val  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      blk_q       <= '0;
      rkey_q      <= '0;
      cryptokey_q <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          blk_q   <= data_in ^ key ^ chain_val;
          rkey_q  <= key;
          cnt_q   <= '0;
          state_q <= ROUND;
        end
        ROUND: begin
          blk_q  <= stage_state[ROUNDS_PER_CYCLE];
          rkey_q <= stage_key[ROUNDS_PER_CYCLE];
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(ITERS - 1)) begin
            cryptokey_q <= stage_state[ROUNDS_PER_CYCLE];
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ROUND);
  assign cryptokey = cryptokey_q;

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core: behavioural AES model plus known-answer vectors.
module tb_aes_iter_core;

  parameter int RPC = 1;
  localparam int ITERS  = 10 / RPC;
  localparam int RST_AT = (ITERS < 4) ? ITERS : 4;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] SP_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_IV    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP_PT1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_PT2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
`ifdef AES_ITER_CBC_EN
  localparam logic [127:0] SP_CT1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] SP_CT2   = 128'h5086cb9b507219ee95db113a917678b2;
`else
  localparam logic [127:0] SP_CT1   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] SP_CT2   = 128'hf5d3d58503b9699de785895a96fdbaaf;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [127:0] key = '0;
  logic [127:0] iv = '0;
  logic         chain_start = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] cryptokey;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox_m [256];

  aes_iter_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .key         (key),
    .iv          (iv),
    .chain_start (chain_start),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cryptokey   (cryptokey),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from first principles: GF(2^8) inverse then the affine map.
  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  function automatic logic [127:0] aes_model(input logic [127:0] key_in, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [4][4];
    logic [7:0]   tmp [4];
    logic [7:0]   coef;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = key_in[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = sbox_m[s[r][c]];
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) tmp[c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++) s[r][c] = tmp[c];
      end
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) begin
            tmp[r] = 8'h00;
            for (int k = 0; k < 4; k++) begin
              coef = ((k - r + 4) % 4 == 0) ? 8'h02 : ((k - r + 4) % 4 == 1) ? 8'h03 : 8'h01;
              tmp[r] = tmp[r] ^ gmul(coef, s[k][c]);
            end
          end
          for (int r = 0; r < 4; r++) s[r][c] = tmp[r];
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    ct = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) ct[127-8*(4*c+r) -: 8] = s[r][c];
    return ct;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Protocol model: 0 idle, 1 computing (m_left edges to go), 2 holding a result.
  int           m_mode = 0;
  int           m_left = 0;
  bit           m_live = 1'b0;
  logic [127:0] m_pending = '0;
  logic [127:0] m_out = '0;
  logic [127:0] m_chain = '0;

  always @(posedge clk) begin
    logic [127:0] cv;
    if (reset) begin
      m_live = 1'b1; m_mode = 0; m_left = 0; m_out = '0; m_chain = '0;
    end else if (m_live) begin
      case (m_mode)
        0: if (in_valid) begin
`ifdef AES_ITER_CBC_EN
          cv = chain_start ? iv : m_chain;
`else
          cv = '0;
`endif
          m_pending = aes_model(key, data_in ^ cv);
          m_left = ITERS;
          m_mode = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin m_out = m_pending; m_mode = 2; end
        end
        default: if (out_ready) begin m_chain = m_out; m_mode = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("model_in_ready",  128'(in_ready),  128'(m_mode == 0));
      checkOutput("model_busy",      128'(busy),      128'(m_mode == 1));
      checkOutput("model_out_valid", 128'(out_valid), 128'(m_mode == 2));
      checkOutput("model_cryptokey", cryptokey, m_out);
    end
  end

  task automatic waitDone(input bit toggle, output int lat);
    lat = 0;
    while (!out_valid && lat < ITERS + 5) begin
      if (toggle) begin
        data_in = ~data_in;
        key = key ^ {4{32'hdeadbeef}};
        iv = ~iv;
        chain_start = ~chain_start;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] k,
                               input logic [127:0] v, input logic cs, input bit toggle);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("accept_ready", 128'(in_ready), 128'(1));
    data_in = pt; key = k; iv = v; chain_start = cs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitDone(toggle, lat);
    checkOutput("latency", 128'(lat), 128'(ITERS));
  endtask

  task automatic takeResult(input logic [127:0] expected, input int hold);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("hold_stable", cryptokey, expected);
      checkOutput("hold_in_ready", 128'(in_ready), 128'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_after_take", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_in_ready",  128'(in_ready),  128'(1));
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_busy",      128'(busy),      128'(0));
    checkOutput("reset_cryptokey", cryptokey, 128'h0);

    applyStimulus(FIPS_PT, FIPS_KEY, '0, 1'b1, 1'b0);
    checkOutput("fips197", cryptokey, FIPS_CT);
    takeResult(FIPS_CT, 0);

    applyStimulus(SP_PT1, SP_KEY, SP_IV, 1'b1, 1'b0);
    checkOutput("sp800_blk1", cryptokey, SP_CT1);
    takeResult(SP_CT1, 0);
    applyStimulus(SP_PT2, SP_KEY, SP_IV, 1'b0, 1'b0);
    checkOutput("sp800_blk2", cryptokey, SP_CT2);
    takeResult(SP_CT2, 2);

    // Inputs churn after accept; then hold the result under backpressure.
    applyStimulus(FIPS_PT, FIPS_KEY, '0, 1'b1, 1'b1);
    checkOutput("toggle_inputs", cryptokey, FIPS_CT);
    for (int k = 0; k < 7; k++) begin
      in_valid = k[0];
      data_in = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("bp_stable", cryptokey, FIPS_CT);
      checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    end
    data_in = FIPS_PT; key = FIPS_KEY; iv = '0; chain_start = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle", 128'(in_ready), 128'(1));
    checkOutput("bp_not_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("late_accept", 128'(busy), 128'(1));
    waitDone(1'b0, lat);
    checkOutput("late_latency", 128'(lat), 128'(ITERS));
    checkOutput("late_ct", cryptokey, FIPS_CT);
    takeResult(FIPS_CT, 0);

    // Reset partway through a block.
    data_in = FIPS_PT; key = FIPS_KEY; iv = '0; chain_start = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (RST_AT - 1) begin @(posedge clk); #1; end
    checkOutput("pre_reset_busy", 128'(busy), 128'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy",      128'(busy),      128'(0));
    checkOutput("rst_cryptokey", cryptokey, 128'h0);
    repeat (ITERS + 3) begin
      @(posedge clk); #1;
      checkOutput("no_out_after_reset", 128'(out_valid), 128'(0));
    end
    applyStimulus(FIPS_PT, FIPS_KEY, '0, 1'b1, 1'b0);
    checkOutput("fips_after_reset", cryptokey, FIPS_CT);
    takeResult(FIPS_CT, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1, giving the number of AES rounds evaluated per clock; legal values are 1, 2 and 5.
REQ-002 The block SHALL derive ITERS = 10 / ROUNDS_PER_CYCLE; any other parameter value SHALL fail elaboration.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a block is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the core can accept a block.
REQ-007 The block SHALL have port data_in, input, 128 bits: plaintext, sampled at accept.
REQ-008 The block SHALL have port key, input, 128 bits: AES-128 cipher key, sampled at accept.
REQ-009 The block SHALL have port iv, input, 128 bits: CBC initialisation vector, sampled at accept.
REQ-010 The block SHALL have port chain_start, input, 1 bit: when 1 at accept, chain from iv instead of the previous ciphertext.
REQ-011 The block SHALL have port out_valid, output, 1 bit: cryptokey holds a finished ciphertext.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port cryptokey, output, 128 bits: the ciphertext.
REQ-014 The block SHALL have port busy, output, 1 bit: high in ROUND state.

Function
REQ-015 The block SHALL be a state machine with states IDLE, ROUND and DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 On accept (in_valid && in_ready), the block SHALL load state = data_in ^ key ^ chain_val, load round key = key, clear the iteration counter and enter ROUND.
REQ-017 In ROUND, each cycle SHALL apply ROUNDS_PER_CYCLE rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) with the next round key expanded on the fly using rcon indexed by the absolute round number.
REQ-018 Round 10 SHALL omit MixColumns; the iteration containing round 10 SHALL write cryptokey and enter DONE.
REQ-019 The latency from the accept edge to out_valid=1 SHALL be exactly ITERS cycles: 10, 5 and 2 for R=1, 2 and 5.
REQ-020 In DONE, cryptokey SHALL be held stable until out_ready=1; that edge returns the block to IDLE. Throughput is therefore one block per ITERS+2 cycles at best.
REQ-021 in_valid SHALL be ignored outside IDLE.
REQ-022 Changes to data_in, key, iv or chain_start after accept SHALL have no effect on the block in flight.
REQ-023 A simultaneous out handshake and in_valid in DONE SHALL accept nothing; the new block is accepted in the following IDLE cycle.

Reset
REQ-024 reset=1 at a clock edge SHALL force IDLE, counter=0, state and round-key registers to 0, cryptokey=0 and the chain register to 0, from any state.
REQ-025 A reset in ROUND or DONE SHALL discard the block without asserting out_valid.
REQ-026 After reset, in_ready SHALL be 1 and out_valid and busy SHALL be 0.

Configuration
REQ-027 Macro AES_ITER_CBC_EN defined: chain_val = iv when chain_start=1, otherwise the chain register; the chain register loads cryptokey on each out handshake.
REQ-028 Macro AES_ITER_CBC_EN undefined: chain_val = 0 (ECB), no chain register is built, and iv and chain_start remain ports but are ignored.

Structure
REQ-029 Package aes_pkg SHALL hold the S-box table, the rcon table, the state enum type, the ITERS constant function and the 128-bit block typedef.
REQ-030 Sub-module aes_round_step SHALL implement one round plus next-key expansion, with inputs state, round_key, rcon and is_final; it SHALL be instantiated ROUNDS_PER_CYCLE times in a chain.

Verification
REQ-031 FIPS-197 ECB, all R values: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> cryptokey 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly ITERS cycles after accept.
REQ-032 SP800-38A CBC (CBC_EN): key 2b7e151628aed2a6abf7158809cf4f3c, iv 000102..0f, chain_start=1, pt 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; then chain_start=0, pt ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2.
REQ-033 Without CBC_EN, same key and pt 6bc1bee22e409f96e93d7e117393172a -> 3ad77bb40d7a3660a89ecaf32466ef97, regardless of iv.
REQ-034 Backpressure: out_ready=0 for 7 cycles in DONE -> cryptokey stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-035 Reset at the 4th ROUND cycle -> IDLE next cycle, out_valid never asserted; a new FIPS-197 block then yields 69c4e0d8... correctly.
REQ-036 Input changes: data_in and key toggled every cycle after accept -> the result matches the values sampled at accept.
